uart_tx_fifo: RTL

UART transmitter with a byte FIFO. It is the transmit-side counterpart of uart_rx and uses the same 8N1 frame format and baud parameters. Upstream logic pushes bytes with a valid/ready handshake, and the block serialises them LSB-first on tx. Frames are sent back-to-back while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a byte FIFO, sending frames back-to-back while data is queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, baud_end, has_data;

    assign ready    = fifo_count != FULL;
    assign push     = data_valid && ready;
    assign has_data = fifo_count != '0;
    assign baud_end = baud == LAST;
    assign busy     = state != IDLE;

    always_comb begin
        state_n = state;
        baud_n  = baud_end ? '0 : baud + CW'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (has_data) begin
                    pop     = 1'b1;
                    state_n = START;
                    bit_n   = '0;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                end
            end
            START: if (baud_end) begin
                state_n = DATA;
                tx_n    = shift[0];
            end
            DATA: if (baud_end) begin
                if (bit_idx == 3'd7) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else begin
                    bit_n   = bit_idx + 3'd1;
                    shift_n = {1'b0, shift[7:1]};
                    tx_n    = shift[1];
                end
            end
            STOP: if (baud_end) begin
                // Chain straight into the next START so queued frames have no idle gap
                if (has_data) begin
                    pop     = 1'b1;
                    state_n = START;
                    bit_n   = '0;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            tx         <= tx_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (data_valid && !ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end
endmodule
